// File: rtl/matrix_inverse_gj_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// matrix_inverse_gj_seq : sequential Gauss-Jordan NxN Q-format inverter with
// partial pivoting, singular detection and one shared reciprocal per column.
// Revision 1.0
// ---------------------------------------------------------------------------
module matrix_inverse_gj_seq #(
    parameter int N    = 5,
    parameter int W    = 16,
    parameter int FRAC = 8,
    parameter int EPS  = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         out_singular,
    output logic         busy
);

    localparam int IW = $clog2(N);
    localparam int W1 = W + 1;
    localparam int W2 = 2 * W;
    localparam int QW = W + FRAC;
    localparam int CW = $clog2(QW);

    localparam logic [IW-1:0] LAST     = IW'(N - 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(QW - 1);
    localparam logic [W1-1:0] EPS_U    = W1'(EPS);
    localparam logic [W-1:0]  ONE      = {{(W-1){1'b0}}, 1'b1} << FRAC;
    localparam logic [QW-1:0] DIVIDEND = {{(QW-1){1'b0}}, 1'b1} << (2 * FRAC);
    localparam logic [QW-1:0] Q_POS    = {{(QW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic [QW-1:0] Q_NEG    = {{(QW-W){1'b0}}, 1'b1, {(W-1){1'b0}}};

    localparam logic signed [W-1:0]  MAXV = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]  MINV = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W2-1:0] P_HI = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [W2-1:0] P_LO = {{(W+1){1'b1}}, {(W-1){1'b0}}};
    localparam logic signed [W1-1:0] D_HI = {2'b00, {(W-1){1'b1}}};
    localparam logic signed [W1-1:0] D_LO = {2'b11, {(W-1){1'b0}}};

    localparam logic [2:0] S_LOAD   = 3'd0;
    localparam logic [2:0] S_SEARCH = 3'd1;
    localparam logic [2:0] S_SWAP   = 3'd2;
    localparam logic [2:0] S_RECIP  = 3'd3;
    localparam logic [2:0] S_NORM   = 3'd4;
    localparam logic [2:0] S_ELIM   = 3'd5;
    localparam logic [2:0] S_OUTPUT = 3'd6;

    // Q-format product: full 2W-bit product, floor shift, saturate.
    function automatic logic signed [W-1:0] mul_q(input logic signed [W-1:0] x,
                                                  input logic signed [W-1:0] y);
        logic signed [W2-1:0] p;
        p = W2'(x) * W2'(y);
        p = p >>> FRAC;
        if (p > P_HI)      return MAXV;
        else if (p < P_LO) return MINV;
        else               return p[W-1:0];
    endfunction

    function automatic logic signed [W-1:0] sub_sat(input logic signed [W-1:0] x,
                                                    input logic signed [W-1:0] y);
        logic signed [W1-1:0] d;
        d = W1'(x) - W1'(y);
        if (d > D_HI)      return MAXV;
        else if (d < D_LO) return MINV;
        else               return d[W-1:0];
    endfunction

    function automatic logic [W-1:0] abs_w(input logic signed [W-1:0] v);
        logic [W-1:0] u;
        u = v;
        return v[W-1] ? (~u + 1'b1) : u;
    endfunction

    logic [2:0]    state_q, state_d;
    logic [IW-1:0] k_q, k_d;
    logic [IW-1:0] r_q, r_d;
    logic [IW-1:0] row_q, row_d;
    logic [IW-1:0] col_q, col_d;
    logic [IW-1:0] p_q, p_d;
    logic [W-1:0]  max_q, max_d;
    logic          neg_q, neg_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [QW-1:0] quo_q, quo_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic          sing_q, sing_d;
    logic          ovalid_q, ovalid_d;

    logic signed [W-1:0] a_q [N][N];
    logic signed [W-1:0] a_d [N][N];
    logic signed [W-1:0] i_q [N][N];
    logic signed [W-1:0] i_d [N][N];

    logic [W-1:0]        w_abs;
    logic [W:0]          w_rem_sh;
    logic signed [W-1:0] w_recip;
    logic signed [W-1:0] w_scale;
    logic signed [W-1:0] w_pa [N];
    logic signed [W-1:0] w_pi [N];

    assign in_ready     = (state_q == S_LOAD);
    assign busy         = (state_q != S_LOAD);
    assign out_valid    = ovalid_q;
    assign out_singular = ovalid_q & sing_q;
    assign out_last     = ovalid_q && (row_q == LAST) && (col_q == LAST);
    assign out_data     = sing_q ? '0 : i_q[row_q][col_q];

    // Divider step and signed, saturated reciprocal from the finished quotient.
    always_comb begin
        w_rem_sh = {rem_q, quo_q[QW-1]};
        if (!neg_q) begin
            w_recip = (quo_q > Q_POS) ? MAXV : quo_q[W-1:0];
        end else begin
            w_recip = (quo_q > Q_NEG) ? MINV : -(quo_q[W-1:0]);
        end
    end

    // One multiplier bank per array: row k times R in NORM, times A[i][k] in ELIM.
    always_comb begin
        w_scale = (state_q == S_NORM) ? w_recip : a_q[r_q][k_q];
        for (int c = 0; c < N; c++) begin
            w_pa[c] = mul_q(a_q[k_q][c], w_scale);
            w_pi[c] = mul_q(i_q[k_q][c], w_scale);
        end
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        r_d      = r_q;
        row_d    = row_q;
        col_d    = col_q;
        p_d      = p_q;
        max_d    = max_q;
        neg_d    = neg_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cyc_d    = cyc_q;
        sing_d   = sing_q;
        ovalid_d = ovalid_q;
        a_d      = a_q;
        i_d      = i_q;
        w_abs    = abs_w(a_q[r_q][k_q]);

        case (state_q)
            S_LOAD: begin
                for (int rr = 0; rr < N; rr++) begin
                    for (int cc = 0; cc < N; cc++) begin
                        i_d[rr][cc] = (rr == cc) ? ONE : '0;
                    end
                end
                if (in_valid) begin
                    a_d[row_q][col_q] = in_data;
                    if (col_q == LAST) begin
                        col_d = '0;
                        if (row_q == LAST) begin
                            row_d   = '0;
                            k_d     = '0;
                            r_d     = '0;
                            state_d = S_SEARCH;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end

            S_SEARCH: begin
                // Strict compare keeps the lowest row on ties.
                if ((r_q == k_q) || (w_abs > max_q)) begin
                    max_d = w_abs;
                    p_d   = r_q;
                    neg_d = a_q[r_q][k_q][W-1];
                end
                if (r_q == LAST) begin
                    if ({1'b0, max_d} <= EPS_U) begin
                        sing_d  = 1'b1;
                        row_d   = '0;
                        col_d   = '0;
                        state_d = S_OUTPUT;
                    end else begin
                        state_d = S_SWAP;
                    end
                end else begin
                    r_d = r_q + 1'b1;
                end
            end

            S_SWAP: begin
                if (p_q != k_q) begin
                    for (int c = 0; c < N; c++) begin
                        a_d[k_q][c] = a_q[p_q][c];
                        a_d[p_q][c] = a_q[k_q][c];
                        i_d[k_q][c] = i_q[p_q][c];
                        i_d[p_q][c] = i_q[k_q][c];
                    end
                end
                rem_d   = '0;
                quo_d   = DIVIDEND;
                cyc_d   = '0;
                state_d = S_RECIP;
            end

            S_RECIP: begin
                if (w_rem_sh >= {1'b0, max_q}) begin
                    rem_d = W'(w_rem_sh - {1'b0, max_q});
                    quo_d = {quo_q[QW-2:0], 1'b1};
                end else begin
                    rem_d = w_rem_sh[W-1:0];
                    quo_d = {quo_q[QW-2:0], 1'b0};
                end
                if (cyc_q == CYC_LAST) begin
                    state_d = S_NORM;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end

            S_NORM: begin
                for (int c = 0; c < N; c++) begin
                    a_d[k_q][c] = w_pa[c];
                    i_d[k_q][c] = w_pi[c];
                end
                r_d     = '0;
                state_d = S_ELIM;
            end

            S_ELIM: begin
                if (r_q != k_q) begin
                    for (int c = 0; c < N; c++) begin
                        a_d[r_q][c] = sub_sat(a_q[r_q][c], w_pa[c]);
                        i_d[r_q][c] = sub_sat(i_q[r_q][c], w_pi[c]);
                    end
                end
                if (r_q == LAST) begin
                    if (k_q == LAST) begin
                        row_d   = '0;
                        col_d   = '0;
                        state_d = S_OUTPUT;
                    end else begin
                        k_d     = k_q + 1'b1;
                        r_d     = k_q + 1'b1;
                        state_d = S_SEARCH;
                    end
                end else begin
                    r_d = r_q + 1'b1;
                end
            end

            S_OUTPUT: begin
                // First cycle here only raises out_valid; the burst follows.
                if (!ovalid_q) begin
                    ovalid_d = 1'b1;
                end else if (out_ready) begin
                    if (col_q == LAST) begin
                        col_d = '0;
                        if (row_q == LAST) begin
                            row_d    = '0;
                            ovalid_d = 1'b0;
                            sing_d   = 1'b0;
                            state_d  = S_LOAD;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end

            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_LOAD;
            k_q      <= '0;
            r_q      <= '0;
            row_q    <= '0;
            col_q    <= '0;
            p_q      <= '0;
            max_q    <= '0;
            neg_q    <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            cyc_q    <= '0;
            sing_q   <= 1'b0;
            ovalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            r_q      <= r_d;
            row_q    <= row_d;
            col_q    <= col_d;
            p_q      <= p_d;
            max_q    <= max_d;
            neg_q    <= neg_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cyc_q    <= cyc_d;
            sing_q   <= sing_d;
            ovalid_q <= ovalid_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q <= a_d;
        i_q <= i_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_inverse_gj_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_matrix_inverse_gj_seq : directed checks of the inverter, N=5 and N=2.
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_matrix_inverse_gj_seq;

    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [1:0]          in_valid;
    logic [1:0]          out_ready;
    logic [1:0][W-1:0]   in_data;
    wire  [1:0]          in_ready;
    wire  [1:0]          out_valid;
    wire  [1:0][W-1:0]   out_data;
    wire  [1:0]          out_last;
    wire  [1:0]          out_singular;
    wire  [1:0]          busy;

    int checks = 0;
    int errors = 0;

    matrix_inverse_gj_seq #(.N(5), .W(W), .FRAC(8), .EPS(0)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_last(out_last[0]), .out_singular(out_singular[0]), .busy(busy[0])
    );

    matrix_inverse_gj_seq #(.N(2), .W(W), .FRAC(8), .EPS(0)) dut_n2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_last(out_last[1]), .out_singular(out_singular[1]), .busy(busy[1])
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the last accept.
    task automatic load_matrix(input int u, input int nn, input logic [W-1:0] m [25]);
        check($sformatf("u%0d in_ready before load", u), W'(in_ready[u]), 16'd1);
        for (int n = 0; n < nn * nn; n++) begin
            in_valid[u] = 1'b1;
            in_data[u]  = m[n];
            @(negedge clk);
        end
        in_valid[u] = 1'b0;
    endtask

    // Optionally drives junk on the input while busy; it must be ignored.
    task automatic wait_valid(input int u, input bit junk, output int cnt);
        cnt = 0;
        while (!out_valid[u] && cnt < 2000) begin
            in_valid[u] = junk && (cnt < 40);
            in_data[u]  = 16'h7FFF;
            @(negedge clk);
            cnt++;
        end
        in_valid[u] = 1'b0;
        check($sformatf("u%0d out_valid within bound", u), W'(out_valid[u]), 16'd1);
    endtask

    task automatic collect(input int u, input int nn, input logic [W-1:0] exp [25],
                           input bit exp_sing, input bit rnd, input string name);
        int idx = 0;
        int cyc = 0;
        bit stalled = 0;
        logic [W-1:0] held = '0;
        logic held_last = 1'b0;
        while (idx < nn * nn && cyc < 3000) begin
            if (out_valid[u]) begin
                if (stalled) begin
                    check($sformatf("%s stall data w%0d", name, idx), out_data[u], held);
                    check($sformatf("%s stall last w%0d", name, idx), W'(out_last[u]), W'(held_last));
                end
                out_ready[u] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (out_ready[u]) begin
                    check($sformatf("%s data w%0d", name, idx), out_data[u], exp[idx]);
                    check($sformatf("%s last w%0d", name, idx), W'(out_last[u]),
                          W'(idx == nn * nn - 1));
                    check($sformatf("%s singular w%0d", name, idx), W'(out_singular[u]), W'(exp_sing));
                    idx++;
                    stalled = 0;
                end else begin
                    stalled   = 1;
                    held      = out_data[u];
                    held_last = out_last[u];
                end
            end
            @(negedge clk);
            cyc++;
        end
        out_ready[u] = 1'b0;
        check($sformatf("%s word count", name), W'(idx), W'(nn * nn));
        check($sformatf("%s out_valid after burst", name), W'(out_valid[u]), 16'd0);
        check($sformatf("%s out_singular after burst", name), W'(out_singular[u]), 16'd0);
        check($sformatf("%s in_ready after burst", name), W'(in_ready[u]), 16'd1);
    endtask

    logic [W-1:0] m_id   [25];
    logic [W-1:0] m_diag [25];
    logic [W-1:0] e_diag [25];
    logic [W-1:0] m_sing [25];
    logic [W-1:0] e_zero [25];
    logic [W-1:0] m_swap [25];
    logic [W-1:0] m_gen  [25];
    logic [W-1:0] e_gen  [25];

    initial begin
        int lat;
        bit seen;

        rst       = 1'b1;
        in_valid  = '0;
        out_ready = '0;
        in_data   = '0;

        for (int i = 0; i < 25; i++) begin
            m_id[i]   = (i % 6 == 0) ? 16'h0100 : 16'h0000;
            m_diag[i] = '0;
            e_diag[i] = '0;
            m_sing[i] = '0;
            e_zero[i] = '0;
            m_swap[i] = '0;
            m_gen[i]  = '0;
            e_gen[i]  = '0;
        end
        m_diag[0] = 16'h0200; m_diag[6] = 16'h0400; m_diag[12] = 16'h0100;
        m_diag[18] = 16'h0800; m_diag[24] = 16'h0100;
        e_diag[0] = 16'h0080; e_diag[6] = 16'h0040; e_diag[12] = 16'h0100;
        e_diag[18] = 16'h0020; e_diag[24] = 16'h0100;
        // Rows 2 and 4 both equal e0+e2, so the last pivot is exactly zero.
        m_sing[0] = 16'h0100; m_sing[6] = 16'h0100; m_sing[10] = 16'h0100;
        m_sing[12] = 16'h0100; m_sing[18] = 16'h0100; m_sing[20] = 16'h0100;
        m_sing[22] = 16'h0100;
        m_swap[1] = 16'h0100; m_swap[2] = 16'h0100;
        m_gen[0] = 16'h0100; m_gen[1] = 16'h0200; m_gen[2] = 16'h0300; m_gen[3] = 16'h0400;
        // Truncated reciprocals (85, then 381) give these instead of -2, 1, 1.5, -0.5.
        e_gen[0] = 16'hFE06; e_gen[1] = 16'h00FE; e_gen[2] = 16'h017D; e_gen[3] = 16'hFF81;

        repeat (3) @(negedge clk);
        check("reset in_ready", W'(in_ready[0]), 16'd1);
        check("reset busy", W'(busy[0]), 16'd0);
        check("reset out_valid", W'(out_valid[0]), 16'd0);
        check("reset out_last", W'(out_last[0]), 16'd0);
        check("reset out_singular", W'(out_singular[0]), 16'd0);
        check("reset n2 in_ready", W'(in_ready[1]), 16'd1);
        rst = 1'b0;
        @(negedge clk);

        // Identity, with ignored junk on the input while busy; latency check.
        load_matrix(0, 5, m_id);
        check("t1 busy after load", W'(busy[0]), 16'd1);
        check("t1 in_ready after load", W'(in_ready[0]), 16'd0);
        wait_valid(0, 1'b1, lat);
        check("t1 latency", W'(lat), 16'd171);
        collect(0, 5, m_id, 1'b0, 1'b0, "t1");

        load_matrix(0, 5, m_diag);
        wait_valid(0, 1'b0, lat);
        collect(0, 5, e_diag, 1'b0, 1'b0, "t2");

        load_matrix(1, 2, m_swap);
        wait_valid(1, 1'b0, lat);
        collect(1, 2, m_swap, 1'b0, 1'b0, "t3a");

        load_matrix(1, 2, m_gen);
        wait_valid(1, 1'b0, lat);
        collect(1, 2, e_gen, 1'b0, 1'b0, "t3b");

        load_matrix(0, 5, m_sing);
        wait_valid(0, 1'b0, lat);
        collect(0, 5, e_zero, 1'b1, 1'b0, "t4");

        load_matrix(0, 5, m_diag);
        wait_valid(0, 1'b0, lat);
        collect(0, 5, e_diag, 1'b0, 1'b1, "t5");

        // 85 cycles after the last accept the block is in the column-2 divider.
        load_matrix(0, 5, m_id);
        repeat (85) @(negedge clk);
        check("t6 busy before rst", W'(busy[0]), 16'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6 in_ready after rst", W'(in_ready[0]), 16'd1);
        check("t6 busy after rst", W'(busy[0]), 16'd0);
        check("t6 out_valid after rst", W'(out_valid[0]), 16'd0);
        seen = 0;
        for (int c = 0; c < 250; c++) begin
            seen |= out_valid[0];
            @(negedge clk);
        end
        check("t6 no output after abort", W'(seen), 16'd0);
        load_matrix(0, 5, m_id);
        wait_valid(0, 1'b0, lat);
        check("t6 latency", W'(lat), 16'd171);
        collect(0, 5, m_id, 1'b0, 1'b0, "t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
